aes_iter_ctrl: RTL and testbench

AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

---
 rtl/aes_iter_ctrl_if.sv | 32 +++
 rtl/aes_iter_ctrl.sv | 111 +++++++++++
 tb/tb_aes_iter_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_iter_ctrl_if.sv
// rtl/aes_iter_ctrl_if.sv - job, round-unit and result handshake bundle for aes_iter_ctrl
interface aes_iter_ctrl_if #(
    parameter int KEY_BITS = 128,
    parameter int DATA_W   = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [KEY_BITS-1:0] in_key;

    logic                rnd_req;
    logic [3:0]          rnd_num;
    logic [DATA_W-1:0]   rnd_state;
    logic [KEY_BITS-1:0] rnd_key;
    logic                rnd_ack;
    logic [DATA_W-1:0]   rnd_result;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                busy;

    modport master (
        output in_valid, in_data, in_key, rnd_ack, rnd_result, out_ready,
        input  in_ready, rnd_req, rnd_num, rnd_state, rnd_key, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, rnd_ack, rnd_result, out_ready,
        output in_ready, rnd_req, rnd_num, rnd_state, rnd_key, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES round sequencer driving an external round unit
// Optional abort input enabled by defining AES_ITER_CTRL_ABORT_EN.
module aes_iter_ctrl #(
    parameter int KEY_BITS = 128,
    parameter int DATA_W   = 128
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_ITER_CTRL_ABORT_EN
    input  logic abort,
`endif
    aes_iter_ctrl_if.slave bus
);

    localparam int NR = (KEY_BITS == 128) ? 10 :
                        (KEY_BITS == 192) ? 12 :
                        (KEY_BITS == 256) ? 14 : 0;

    if (NR == 0) begin : g_bad_key_bits
        $error("aes_iter_ctrl: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                fsm;
    logic [3:0]          cnt;
    logic [DATA_W-1:0]   state_q;
    logic [KEY_BITS-1:0] key_q;
    logic                in_ready_q;
    logic                rnd_req_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                abort_i;

`ifdef AES_ITER_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.rnd_req   = rnd_req_q;
    assign bus.rnd_num   = cnt;
    assign bus.rnd_state = state_q;
    assign bus.rnd_key   = key_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            cnt         <= '0;
            state_q     <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            rnd_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= bus.in_data;
                        key_q      <= bus.in_key;
                        cnt        <= '0;
                        fsm        <= RUN;
                        in_ready_q <= 1'b0;
                        rnd_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    // abort wins over a coincident ack: the state register keeps its old value
                    if (abort_i) begin
                        fsm        <= IDLE;
                        cnt        <= '0;
                        rnd_req_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (bus.rnd_ack) begin
                        state_q <= bus.rnd_result;
                        if (cnt == 4'(NR)) begin
                            fsm         <= DONE;
                            rnd_req_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (abort_i || bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    rnd_req_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - scoreboard bench: AES-128 round model on one DUT, counting mock round unit on a KEY_BITS=256 DUT
module tb_aes_iter_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_iter_ctrl_if #(.KEY_BITS(128), .DATA_W(128)) ifa ();
    aes_iter_ctrl_if #(.KEY_BITS(256), .DATA_W(128)) ifb ();

`ifdef AES_ITER_CTRL_ABORT_EN
    logic abort_a;
    logic abort_b;
`endif

    aes_iter_ctrl #(.KEY_BITS(128), .DATA_W(128)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_ITER_CTRL_ABORT_EN
        .abort (abort_a),
`endif
        .bus   (ifa)
    );

    aes_iter_ctrl #(.KEY_BITS(256), .DATA_W(128)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_ITER_CTRL_ABORT_EN
        .abort (abort_b),
`endif
        .bus   (ifb)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural AES round unit (FIPS-197 byte order, column-major state)
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] y;
        inv = 8'h01;
        y   = x;
        for (int i = 1; i < 8; i++) begin
            y   = gmul(y, y);
            inv = gmul(inv, y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [127:0] w;
        logic [31:0]  t;
        logic [7:0]   rc;
        w  = k;
        rc = 8'h01;
        for (int i = 0; i < r; i++) begin
            t = {w[23:0], w[31:24]};
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
            w[127:96] = w[127:96] ^ t;
            w[95:64]  = w[95:64] ^ w[127:96];
            w[63:32]  = w[63:32] ^ w[95:64];
            w[31:0]   = w[31:0] ^ w[63:32];
            rc = xt(rc);
        end
        return w;
    endfunction

    function automatic logic [127:0] aes_round(input logic [3:0] num, input logic [127:0] s,
                                               input logic [127:0] k);
        logic [127:0] o;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        if (num == 4'd0) return s ^ k;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(c*4+r) -: 8] = sb(s[127-8*(((c+r)%4)*4+r) -: 8]);
        m = o;
        if (num != 4'd10) begin
            for (int c = 0; c < 4; c++) begin
                a0 = o[127-32*c -: 8];
                a1 = o[119-32*c -: 8];
                a2 = o[111-32*c -: 8];
                a3 = o[103-32*c -: 8];
                m[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                m[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                m[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return m ^ rkey(k, int'(num));
    endfunction

    assign ifa.rnd_ack    = 1'b1;
    assign ifa.rnd_result = aes_round(ifa.rnd_num, ifa.rnd_state, ifa.rnd_key);

    // Mock round unit for the 256-bit DUT: xor low key half and one bit per round, ack after 3 waits
    logic [2:0] wcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 3'd0;
        else if (ifb.rnd_req && !ifb.rnd_ack) wcnt <= wcnt + 3'd1;
        else wcnt <= 3'd0;
    end
    assign ifb.rnd_ack    = ifb.rnd_req && (wcnt == 3'd3);
    assign ifb.rnd_result = ifb.rnd_state ^ ifb.rnd_key[127:0] ^ (128'd1 << ifb.rnd_num);

    logic [3:0]   qa_num[$];
    logic [3:0]   qb_num[$];
    logic [127:0] qa_out[$];
    logic [127:0] qb_out[$];

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ifa.rnd_req && ifa.rnd_ack) begin
                check("a_rnd_expected", 128'(qa_num.size() != 0), 128'd1);
                if (qa_num.size() != 0) check("a_rnd_num", 128'(ifa.rnd_num), 128'(qa_num.pop_front()));
            end
            if (ifa.out_valid && ifa.out_ready) begin
                check("a_out_expected", 128'(qa_out.size() != 0), 128'd1);
                if (qa_out.size() != 0) check("a_out_data", ifa.out_data, qa_out.pop_front());
            end
        end
    end

    int           hs_b;
    logic         pr_b, pa_b;
    logic [127:0] ps_b;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pr_b = 1'b0;
            pa_b = 1'b0;
        end else begin
            if (pr_b && !pa_b) begin
                check("b_req_held", 128'(ifb.rnd_req), 128'd1);
                check("b_state_stable", ifb.rnd_state, ps_b);
            end
            if (ifb.rnd_req && ifb.rnd_ack) begin
                hs_b++;
                check("b_rnd_expected", 128'(qb_num.size() != 0), 128'd1);
                if (qb_num.size() != 0) check("b_rnd_num", 128'(ifb.rnd_num), 128'(qb_num.pop_front()));
            end
            if (ifb.out_valid && ifb.out_ready) begin
                check("b_out_expected", 128'(qb_out.size() != 0), 128'd1);
                if (qb_out.size() != 0) check("b_out_data", ifb.out_data, qb_out.pop_front());
            end
            pr_b = ifb.rnd_req;
            pa_b = ifb.rnd_ack;
            ps_b = ifb.rnd_state;
        end
    end

    task automatic start_a(input logic [127:0] d, input logic [127:0] k);
        @(posedge clk); #1;
        ifa.in_data  = d;
        ifa.in_key   = k;
        ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        ifa.in_data  = ~d;
        ifa.in_key   = ~k;
    endtask

    task automatic start_b(input logic [127:0] d, input logic [255:0] k);
        @(posedge clk); #1;
        ifb.in_data  = d;
        ifb.in_key   = k;
        ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        ifb.in_data  = ~d;
        ifb.in_key   = ~k;
    endtask

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'hffff0000_ffff0000_ffff0000_ffff0000;
    localparam logic [255:0] KB  = {128'h01234567_89abcdef_01234567_89abcdef,
                                    128'h11111111_11111111_11111111_11111111};
    localparam logic [127:0] CTB = 128'heeee1111_eeee1111_eeee1111_eeee6eee;

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic saw;
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_key = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_key = '0; ifb.out_ready = 1'b1;
`ifdef AES_ITER_CTRL_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_flags", 128'({ifa.in_ready, ifa.rnd_req, ifa.out_valid, ifa.busy, ifa.rnd_num}),
              128'({4'b1000, 4'd0}));
        check("reset_out_data", ifa.out_data, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back rounds with ack tied high: cycle-exact latency and FIPS-197 C.1 vector
        for (int i = 0; i <= 10; i++) qa_num.push_back(4'(i));
        qa_out.push_back(CT1);
        start_a(PT1, K1);
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (j <= 11)
                check("t1_round", 128'({ifa.rnd_req, ifa.in_ready, ifa.rnd_num}), 128'({2'b10, 4'(j - 1)}));
            else if (j == 12)
                check("t1_out_valid", 128'({ifa.out_valid, ifa.in_ready, ifa.busy}), 128'(3'b101));
            else
                check("t1_in_ready", 128'({ifa.out_valid, ifa.in_ready, ifa.busy}), 128'(3'b010));
        end

        // Consumer stalls in DONE while in_valid pulses arrive
        ifa.out_ready = 1'b0;
        for (int i = 0; i <= 10; i++) qa_num.push_back(4'(i));
        qa_out.push_back(CT2);
        start_a(PT2, K2);
        n = 0;
        while (!ifa.out_valid && n < 100) begin @(negedge clk); n++; end
        check("t2_done_reached", 128'(ifa.out_valid), 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ifa.in_valid = (i < 4);
            ifa.in_data  = 128'(i);
            @(negedge clk);
            check("t2_hold_data", ifa.out_data, CT2);
            check("t2_hold_flags", 128'({ifa.out_valid, ifa.in_ready}), 128'(2'b10));
        end
        @(posedge clk); #1;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_back_idle", 128'({ifa.out_valid, ifa.in_ready, ifa.busy}), 128'(3'b010));

        // Asynchronous reset in the middle of round 5
        for (int i = 0; i <= 10; i++) qa_num.push_back(4'(i));
        qa_out.push_back(CT1);
        start_a(PT1, K1);
        n = 0;
        while (!(ifa.rnd_req && ifa.rnd_num == 4'd5) && n < 100) begin @(negedge clk); n++; end
        check("t3_round5_reached", 128'(ifa.rnd_num), 128'd5);
        #1 rst_n = 1'b0;
        #1;
        check("t3_reset_flags", 128'({ifa.in_ready, ifa.rnd_req, ifa.out_valid, ifa.busy, ifa.rnd_num}),
              128'({4'b1000, 4'd0}));
        check("t3_reset_state", ifa.rnd_state | ifa.out_data | ifa.rnd_key, 128'd0);
        qa_num.delete();
        qa_out.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin @(negedge clk); saw = saw | ifa.out_valid | ifa.busy; end
        check("t3_no_out_after_reset", 128'(saw), 128'd0);
        for (int i = 0; i <= 10; i++) qa_num.push_back(4'(i));
        qa_out.push_back(CT2);
        start_a(PT2, K2);
        n = 0;
        while (qa_out.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("t3_new_job_done", 128'(qa_out.size()), 128'd0);

        // KEY_BITS=256 with a slow round unit
        hs_b = 0;
        for (int i = 0; i <= 14; i++) qb_num.push_back(4'(i));
        qb_out.push_back(CTB);
        start_b(PTB, KB);
        n = 0;
        while (qb_out.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("t4_job_done", 128'(qb_out.size()), 128'd0);
        check("t4_handshakes", 128'(hs_b), 128'd15);

`ifdef AES_ITER_CTRL_ABORT_EN
        // Abort coincident with the round-3 ack
        for (int i = 0; i <= 14; i++) qb_num.push_back(4'(i));
        start_b(PTB, KB);
        n = 0;
        while (!(ifb.rnd_req && ifb.rnd_ack && ifb.rnd_num == 4'd3) && n < 100) begin
            @(negedge clk); n++;
        end
        check("t5_round3_ack_reached", 128'(ifb.rnd_num), 128'd3);
        abort_b = 1'b1;
        @(posedge clk); #1;
        abort_b = 1'b0;
        check("t5_abort_flags", 128'({ifb.busy, ifb.in_ready, ifb.rnd_req, ifb.out_valid}), 128'(4'b0100));
        check("t5_abort_state", ifb.rnd_state, 128'heeee1111_eeee1111_eeee1111_eeee1116);
        qb_num.delete();
        repeat (5) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("queues_empty", 128'(qa_num.size() + qa_out.size() + qb_num.size() + qb_out.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
